hufftree_sched: RTL and testbench

- Job scheduler and port arbiter in front of the Huffman tree generator in the inflate core.
- Accepts tree-build jobs (bank, symbol count, code-length buffer bias) into a small FIFO. Launches the generator one job at a time and steers its table writes to the selected decode-table bank.
- Arbitrates the code-length buffer port between the header loader (writes) and the generator (reads). A watchdog detects a generator that never finishes.

---
 rtl/hufftree_sched.sv | 209 ++++++++++++++++++++
 tb/tb_hufftree_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hufftree_sched.sv
// hufftree_sched: job scheduler and buffer-port arbiter for the Huffman tree
// generator.
//
// Jobs (bank, symbol count, buffer bias) are queued in a small FIFO. The
// generator is launched one job at a time. While a job runs, its table writes
// are steered to the selected decode-table bank. The code-length buffer port
// belongs to the header loader only while the scheduler is idle with nothing
// queued. A watchdog halts the scheduler if the generator never finishes.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   job_valid/job_ready            job push handshake
//   job_bank/job_tree_num/job_bias job descriptor
//   job_done/done_bank             registered completion pulse and its bank
//   busy, q_level                  activity flag and FIFO occupancy
//   gen_inc                        generator start pulse
//   gen_tree_num/gen_bias          parameters of the current job
//   gen_buff_addr/gen_winc         generator buffer address, table write strobe
//   gen_finish                     generator completion pulse
//   ldr_we/ldr_addr/ldr_ready      loader buffer write port and grant
//   buf_addr/buf_we                arbitrated code-length buffer port
//   bank_we                        one-hot decode-table write enables
//   err_cfg/err_timeout/err_clr    sticky errors and their clear

module hufftree_sched #(
    parameter int unsigned QDEPTH    = 4,
    parameter int unsigned NBANK     = 3,
    parameter int unsigned TO_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           job_valid,
    output logic                           job_ready,
    input  logic [1:0]                     job_bank,
    input  logic [5:0]                     job_tree_num,
    input  logic [5:0]                     job_bias,
    output logic                           job_done,
    output logic [1:0]                     done_bank,
    output logic                           busy,
    output logic [$clog2(QDEPTH+1)-1:0]    q_level,
    output logic                           gen_inc,
    output logic [5:0]                     gen_tree_num,
    output logic [5:0]                     gen_bias,
    input  logic [8:0]                     gen_buff_addr,
    input  logic                           gen_winc,
    input  logic                           gen_finish,
    input  logic                           ldr_we,
    input  logic [8:0]                     ldr_addr,
    output logic                           ldr_ready,
    output logic [8:0]                     buf_addr,
    output logic                           buf_we,
    output logic [NBANK-1:0]               bank_we,
    output logic                           err_cfg,
    output logic                           err_timeout,
    input  logic                           err_clr
);

    localparam int unsigned QW = $clog2(QDEPTH + 1);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned WW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_HALT
    } state_t;

    state_t state, state_nx;

    logic [1:0]    q_bank [QDEPTH];
    logic [5:0]    q_tree [QDEPTH];
    logic [5:0]    q_bias [QDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [QW-1:0] count;

    logic [1:0]    cur_bank;
    logic [5:0]    cur_tree_num;
    logic [5:0]    cur_bias;
    logic [WW-1:0] wd_cnt;

    logic empty, full, cfg_ok, push, cfg_err, pop, timeout;

    assign empty  = (count == '0);
    assign full   = (count == QW'(QDEPTH));
    assign cfg_ok = (32'(job_bank) < NBANK) && (job_tree_num != '0);

    // A rejected job still consumes the handshake; it just never enters the FIFO.
    assign push    = job_valid & job_ready & cfg_ok;
    assign cfg_err = job_valid & job_ready & ~cfg_ok;

    // Next-state logic. Finishing with work queued goes straight to LAUNCH,
    // skipping IDLE, so back-to-back jobs lose no cycle.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        timeout  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = S_LAUNCH;
                end
            end
            S_LAUNCH: state_nx = S_RUN;
            S_RUN: begin
                if (gen_finish) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        state_nx = S_LAUNCH;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else if (wd_cnt == WW'(TO_CYCLES - 1)) begin
                    timeout  = 1'b1;
                    state_nx = S_HALT;
                end
            end
            S_HALT: begin
                if (err_clr) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // FIFO storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_bank[wr_ptr] <= job_bank;
            q_tree[wr_ptr] <= job_tree_num;
            q_bias[wr_ptr] <= job_bias;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_bank     <= '0;
            cur_tree_num <= '0;
            cur_bias     <= '0;
            wd_cnt       <= '0;
            job_done     <= 1'b0;
            done_bank    <= '0;
            err_cfg      <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (pop) begin
                cur_bank     <= q_bank[rd_ptr];
                cur_tree_num <= q_tree[rd_ptr];
                cur_bias     <= q_bias[rd_ptr];
            end

            // RUN is only ever entered from LAUNCH, so clearing there restarts
            // the watchdog on every entry.
            if (state == S_LAUNCH)  wd_cnt <= '0;
            else if (state == S_RUN) wd_cnt <= wd_cnt + 1'b1;

            job_done <= (state == S_RUN) & gen_finish;
            if ((state == S_RUN) && gen_finish) done_bank <= cur_bank;

            // A new error event outranks a simultaneous clear.
            if (cfg_err)      err_cfg <= 1'b1;
            else if (err_clr) err_cfg <= 1'b0;

            if (timeout)      err_timeout <= 1'b1;
            else if (err_clr) err_timeout <= 1'b0;
        end
    end

    always_comb begin
        bank_we = '0;
        if ((state == S_RUN) && gen_winc) begin
            for (int unsigned b = 0; b < NBANK; b++) begin
                bank_we[b] = (32'(cur_bank) == b);
            end
        end
    end

    assign job_ready    = ~full;
    assign busy         = (state != S_IDLE) || !empty;
    assign q_level      = count;
    assign gen_inc      = (state == S_LAUNCH);
    assign gen_tree_num = cur_tree_num;
    assign gen_bias     = cur_bias;
    assign ldr_ready    = (state == S_IDLE) && empty;
    assign buf_addr     = ldr_ready ? ldr_addr : gen_buff_addr;
    assign buf_we       = ldr_we & ldr_ready;

endmodule

// File: tb/tb_hufftree_sched.sv
// tb_hufftree_sched: scoreboard bench for hufftree_sched.
// The main instance uses default parameters; a second instance with
// TO_CYCLES=16 shares all inputs and is only examined in the watchdog phase.
// Expected launches and completions are queued when jobs are pushed. A monitor
// pops and compares them whenever gen_inc or job_done is seen.

module tb_hufftree_sched;

    logic       clk;
    logic       rst_n;
    logic       job_valid;
    logic [1:0] job_bank;
    logic [5:0] job_tree_num;
    logic [5:0] job_bias;
    logic [8:0] gen_buff_addr;
    logic       gen_winc;
    logic       gen_finish;
    logic       ldr_we;
    logic [8:0] ldr_addr;
    logic       err_clr;

    logic       job_ready, job_done, busy, gen_inc, ldr_ready, buf_we, err_cfg, err_timeout;
    logic [1:0] done_bank;
    logic [2:0] q_level;
    logic [5:0] gen_tree_num, gen_bias;
    logic [8:0] buf_addr;
    logic [2:0] bank_we;

    logic       w_job_ready, w_job_done, w_busy, w_gen_inc, w_ldr_ready, w_buf_we, w_err_cfg, w_err_timeout;
    logic [1:0] w_done_bank;
    logic [2:0] w_q_level;
    logic [5:0] w_gen_tree_num, w_gen_bias;
    logic [8:0] w_buf_addr;
    logic [2:0] w_bank_we;

    hufftree_sched #(.QDEPTH(4), .NBANK(3), .TO_CYCLES(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_bank(job_bank),
        .job_tree_num(job_tree_num), .job_bias(job_bias),
        .job_done(job_done), .done_bank(done_bank), .busy(busy), .q_level(q_level),
        .gen_inc(gen_inc), .gen_tree_num(gen_tree_num), .gen_bias(gen_bias),
        .gen_buff_addr(gen_buff_addr), .gen_winc(gen_winc), .gen_finish(gen_finish),
        .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_ready(ldr_ready),
        .buf_addr(buf_addr), .buf_we(buf_we), .bank_we(bank_we),
        .err_cfg(err_cfg), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    hufftree_sched #(.QDEPTH(4), .NBANK(3), .TO_CYCLES(16)) dut_wd (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(w_job_ready), .job_bank(job_bank),
        .job_tree_num(job_tree_num), .job_bias(job_bias),
        .job_done(w_job_done), .done_bank(w_done_bank), .busy(w_busy), .q_level(w_q_level),
        .gen_inc(w_gen_inc), .gen_tree_num(w_gen_tree_num), .gen_bias(w_gen_bias),
        .gen_buff_addr(gen_buff_addr), .gen_winc(gen_winc), .gen_finish(gen_finish),
        .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_ready(w_ldr_ready),
        .buf_addr(w_buf_addr), .buf_we(w_buf_we), .bank_we(w_bank_we),
        .err_cfg(w_err_cfg), .err_timeout(w_err_timeout), .err_clr(err_clr)
    );

    typedef struct packed {
        logic [5:0] tree;
        logic [5:0] bias;
    } launch_t;

    launch_t    exp_launch [$];
    logic [1:0] exp_done   [$];
    logic [1:0] qb [5];
    bit         mon_en;
    int         checks;
    int         failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_job(input logic [1:0] b, input logic [5:0] t, input logic [5:0] s, input bit track);
        job_valid    = 1'b1;
        job_bank     = b;
        job_tree_num = t;
        job_bias     = s;
        if (track) begin
            exp_launch.push_back(launch_t'{t, s});
            exp_done.push_back(b);
        end
    endtask

    task automatic check_reset_main(input string tag);
        chk({tag, "_job_ready"},    32'(job_ready),    1);
        chk({tag, "_ldr_ready"},    32'(ldr_ready),    1);
        chk({tag, "_busy"},         32'(busy),         0);
        chk({tag, "_q_level"},      32'(q_level),      0);
        chk({tag, "_job_done"},     32'(job_done),     0);
        chk({tag, "_done_bank"},    32'(done_bank),    0);
        chk({tag, "_gen_inc"},      32'(gen_inc),      0);
        chk({tag, "_gen_tree_num"}, 32'(gen_tree_num), 0);
        chk({tag, "_gen_bias"},     32'(gen_bias),     0);
        chk({tag, "_bank_we"},      32'(bank_we),      0);
        chk({tag, "_buf_we"},       32'(buf_we),       0);
        chk({tag, "_err_cfg"},      32'(err_cfg),      0);
        chk({tag, "_err_timeout"},  32'(err_timeout),  0);
    endtask

    // Scoreboard monitor: compares each launch and completion against the queues.
    initial begin
        launch_t    e;
        logic [1:0] eb;
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                if (gen_inc) begin
                    if (exp_launch.size() == 0) begin
                        chk("unexpected_gen_inc", 32'(gen_inc), 0);
                    end else begin
                        e = exp_launch.pop_front();
                        chk("launch_tree_num", 32'(gen_tree_num), 32'(e.tree));
                        chk("launch_bias",     32'(gen_bias),     32'(e.bias));
                    end
                end
                if (job_done) begin
                    if (exp_done.size() == 0) begin
                        chk("unexpected_job_done", 32'(job_done), 0);
                    end else begin
                        eb = exp_done.pop_front();
                        chk("done_bank", 32'(done_bank), 32'(eb));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        checks = 0; failures = 0; mon_en = 1'b1;
        rst_n = 1'b0; job_valid = 1'b0; job_bank = '0; job_tree_num = '0; job_bias = '0;
        gen_buff_addr = '0; gen_winc = 1'b0; gen_finish = 1'b0;
        ldr_we = 1'b0; ldr_addr = '0; err_clr = 1'b0;
        qb = '{2'd0, 2'd2, 2'd1, 2'd0, 2'd2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_main("rst");
        tick(); rst_n = 1'b1;

        // Single job: bank 1, 19 symbols, finish 40 cycles after gen_inc.
        tick();
        drive_job(2'd1, 6'd19, 6'd0, 1'b1);
        @(negedge clk); chk("c0_ldr_ready", 32'(ldr_ready), 1);
        tick(); job_valid = 1'b0;
        @(negedge clk);
        chk("c1_q_level", 32'(q_level), 1);
        chk("c1_gen_inc", 32'(gen_inc), 0);
        chk("c1_ldr_ready", 32'(ldr_ready), 0);
        chk("c1_busy", 32'(busy), 1);
        tick();
        @(negedge clk);
        chk("c2_gen_inc", 32'(gen_inc), 1);
        chk("c2_q_level", 32'(q_level), 0);
        for (int i = 1; i <= 39; i++) begin
            tick();
            gen_winc = (i % 8 == 0);
            gen_buff_addr = 9'(i);
            @(negedge clk);
            if (gen_winc) chk("single_bank_we", 32'(bank_we), 32'b010);
            if (i == 20) chk("single_tree_held", 32'(gen_tree_num), 19);
        end
        tick(); gen_winc = 1'b0; gen_finish = 1'b1;
        @(negedge clk); chk("single_done_early", 32'(job_done), 0);
        tick(); gen_finish = 1'b0; gen_winc = 1'b1;
        @(negedge clk);
        chk("single_job_done", 32'(job_done), 1);
        chk("single_busy_fall", 32'(busy), 0);
        chk("winc_outside_run", 32'(bank_we), 0);
        tick(); gen_winc = 1'b0;
        @(negedge clk); chk("single_done_pulse", 32'(job_done), 0);

        // Queue full: five back-to-back pushes with the generator stalled.
        for (int k = 0; k < 5; k++) begin
            tick();
            drive_job(qb[k], 6'(21 + k), 6'(40 + k), 1'b1);
            @(negedge clk); chk("full_ready_pre", 32'(job_ready), 1);
        end
        tick();
        drive_job(2'd2, 6'd63, 6'd63, 1'b0);
        @(negedge clk);
        chk("full_job_ready", 32'(job_ready), 0);
        chk("full_q_level", 32'(q_level), 4);
        tick(); job_valid = 1'b0;
        @(negedge clk); chk("full_drop_extra", 32'(q_level), 4);
        for (int k = 0; k < 5; k++) begin
            repeat (3) tick();
            gen_finish = 1'b1;
            tick(); gen_finish = 1'b0;
            @(negedge clk);
            chk("full_job_done", 32'(job_done), 1);
            chk("full_relaunch", 32'(gen_inc), (k < 4) ? 1 : 0);
            chk("full_q_after", 32'(q_level), (k < 4) ? 32'(3 - k) : 0);
        end
        tick();
        @(negedge clk);
        chk("full_all_done", 32'(exp_done.size()), 0);

        // Configuration errors.
        tick(); drive_job(2'd3, 6'd5, 6'd1, 1'b0);
        tick(); job_valid = 1'b0;
        @(negedge clk);
        chk("cfg_bank_err", 32'(err_cfg), 1);
        chk("cfg_bank_q", 32'(q_level), 0);
        chk("cfg_bank_busy", 32'(busy), 0);
        tick(); drive_job(2'd0, 6'd0, 6'd1, 1'b0);
        tick(); job_valid = 1'b0;
        @(negedge clk);
        chk("cfg_tree_q", 32'(q_level), 0);
        chk("cfg_tree_err", 32'(err_cfg), 1);
        tick(); err_clr = 1'b1; drive_job(2'd2, 6'd0, 6'd0, 1'b0);
        tick(); err_clr = 1'b0; job_valid = 1'b0;
        @(negedge clk); chk("cfg_set_wins", 32'(err_cfg), 1);
        tick(); err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        @(negedge clk); chk("cfg_cleared", 32'(err_cfg), 0);

        // Buffer arbitration.
        tick(); ldr_we = 1'b1; ldr_addr = 9'h005; gen_buff_addr = 9'h1F0;
        @(negedge clk);
        chk("arb_idle_we", 32'(buf_we), 1);
        chk("arb_idle_addr", 32'(buf_addr), 32'h005);
        tick(); ldr_we = 1'b0; drive_job(2'd2, 6'd7, 6'd9, 1'b1);
        tick(); job_valid = 1'b0;
        tick();
        tick(); ldr_we = 1'b1; ldr_addr = 9'h033; gen_buff_addr = 9'h12A; gen_winc = 1'b1;
        @(negedge clk);
        chk("arb_run_we", 32'(buf_we), 0);
        chk("arb_run_addr", 32'(buf_addr), 32'h12A);
        chk("arb_run_ldr_ready", 32'(ldr_ready), 0);
        chk("arb_run_bank_we", 32'(bank_we), 32'b100);
        chk("arb_run_tree", 32'(gen_tree_num), 7);
        chk("arb_run_bias", 32'(gen_bias), 9);
        tick(); ldr_we = 1'b0; gen_winc = 1'b0; gen_finish = 1'b1;
        tick(); gen_finish = 1'b0;
        @(negedge clk); chk("arb_job_done", 32'(job_done), 1);
        tick();
        @(negedge clk);
        chk("arb_done_queue", 32'(exp_done.size()), 0);
        chk("arb_launch_queue", 32'(exp_launch.size()), 0);

        // Watchdog on the TO_CYCLES=16 instance.
        mon_en = 1'b0;
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        exp_launch.delete(); exp_done.delete();
        tick(); drive_job(2'd0, 6'd3, 6'd1, 1'b0);
        tick(); drive_job(2'd2, 6'd4, 6'd2, 1'b0);
        tick(); job_valid = 1'b0;
        @(negedge clk);
        chk("wd_launch", 32'(w_gen_inc), 1);
        chk("wd_launch_tree", 32'(w_gen_tree_num), 3);
        for (int i = 0; i < 16; i++) begin
            tick();
            @(negedge clk);
            chk("wd_no_timeout_yet", 32'(w_err_timeout), 0);
        end
        tick(); gen_winc = 1'b1;
        @(negedge clk);
        chk("wd_timeout", 32'(w_err_timeout), 1);
        chk("wd_halt_ldr_ready", 32'(w_ldr_ready), 0);
        chk("wd_halt_q_level", 32'(w_q_level), 1);
        chk("wd_halt_bank_we", 32'(w_bank_we), 0);
        chk("wd_halt_busy", 32'(w_busy), 1);
        chk("wd_no_done", 32'(w_job_done), 0);
        tick(); gen_winc = 1'b0; gen_finish = 1'b1;
        tick(); gen_finish = 1'b0;
        @(negedge clk);
        chk("wd_halt_finish_ignored", 32'(w_job_done), 0);
        chk("wd_halt_no_launch", 32'(w_gen_inc), 0);
        repeat (3) tick();
        @(negedge clk);
        chk("wd_halt_still_no_launch", 32'(w_gen_inc), 0);
        chk("wd_timeout_sticky", 32'(w_err_timeout), 1);
        tick(); err_clr = 1'b1;
        @(negedge clk); chk("wd_clr_c0_inc", 32'(w_gen_inc), 0);
        tick(); err_clr = 1'b0;
        @(negedge clk);
        chk("wd_clr_timeout", 32'(w_err_timeout), 0);
        chk("wd_clr_c1_inc", 32'(w_gen_inc), 0);
        tick();
        @(negedge clk);
        chk("wd_relaunch", 32'(w_gen_inc), 1);
        chk("wd_relaunch_tree", 32'(w_gen_tree_num), 4);
        chk("wd_relaunch_bias", 32'(w_gen_bias), 2);
        chk("wd_relaunch_q", 32'(w_q_level), 0);

        // Reset in the middle of RUN with two jobs queued.
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        exp_launch.delete(); exp_done.delete();
        mon_en = 1'b1;
        tick(); drive_job(2'd1, 6'd10, 6'd11, 1'b1);
        tick(); drive_job(2'd0, 6'd12, 6'd13, 1'b1);
        tick(); drive_job(2'd2, 6'd14, 6'd15, 1'b1);
        tick(); job_valid = 1'b0;
        @(negedge clk); chk("mid_q_level", 32'(q_level), 2);
        tick(); gen_winc = 1'b1;
        @(negedge clk); chk("mid_bank_we", 32'(bank_we), 32'b010);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_main("midrst");
        exp_launch.delete(); exp_done.delete();
        gen_winc = 1'b0;
        tick();
        tick(); rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            gen_finish = (i == 2);
            gen_winc   = (i == 3);
            @(negedge clk);
            chk("post_rst_no_done", 32'(job_done), 0);
            if (i == 3) chk("post_rst_bank_we", 32'(bank_we), 0);
        end
        gen_finish = 1'b0; gen_winc = 1'b0;
        chk("post_rst_q_level", 32'(q_level), 0);
        chk("post_rst_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
